// File: rtl/sdram_arbiter.sv
// Slot scheduler sharing one SDRAM controller between ports A and B with periodic auto-refresh.
// Define SDRAM_ARB_RR_EN for round-robin A/B service; default is fixed priority refresh > A > B.
module sdram_arbiter #(
   parameter int SLOT_LEN       = 8,
   parameter int CS_HIGH        = 4,
   parameter int SAMPLE_CYC     = 5,
   parameter int REFRESH_CYCLES = 250
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ram_ready,
   output logic        ram_cs,
   output logic        ram_we,
   output logic        ram_refresh,
   output logic [21:0] ram_addr,
   output logic [15:0] ram_din,
   output logic [1:0]  ram_ds,
   input  logic [15:0] ram_dout,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [21:0] a_addr,
   input  logic [15:0] a_din,
   input  logic [1:0]  a_ds,
   output logic        a_ack,
   output logic [15:0] a_dout,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [21:0] b_addr,
   input  logic [15:0] b_din,
   input  logic [1:0]  b_ds,
   output logic        b_ack,
   output logic [15:0] b_dout
);
   localparam int CW = $clog2(SLOT_LEN);
   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   localparam logic [CW-1:0] CYC_LAST   = CW'(SLOT_LEN - 1);
   localparam logic [CW-1:0] CYC_CS_END = CW'(CS_HIGH - 1);
   localparam logic [CW-1:0] CYC_SAMPLE = CW'(SAMPLE_CYC);
   localparam logic [RW-1:0] REF_LOAD   = RW'(REFRESH_CYCLES);

   typedef enum logic [1:0] {INIT, IDLE, SLOT} state_t;
   typedef enum logic [1:0] {OWN_REF, OWN_A, OWN_B} owner_t;

   state_t        state;
   owner_t        owner;
   logic [CW-1:0] cyc;
   logic [RW-1:0] ref_cnt;
   logic          ref_pending;
   logic          a_ok, b_ok, pick_a, slot_end, start, expire;
`ifdef SDRAM_ARB_RR_EN
   logic          rr_a;
`endif

   // A port is not eligible in the cycle its ack is high: that request is already complete.
   always_comb begin
      a_ok     = a_req && !a_ack;
      b_ok     = b_req && !b_ack;
`ifdef SDRAM_ARB_RR_EN
      pick_a   = a_ok && (!b_ok || rr_a);
`else
      pick_a   = a_ok;
`endif
      slot_end = (state == SLOT) && (cyc == CYC_LAST);
      start    = ((state == IDLE) || slot_end) && (ref_pending || a_ok || b_ok);
      expire   = (state != INIT) && (ref_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= INIT;
         owner       <= OWN_REF;
         cyc         <= '0;
         ref_cnt     <= REF_LOAD;
         ref_pending <= 1'b0;
         ram_cs      <= 1'b0;
         ram_we      <= 1'b0;
         ram_refresh <= 1'b0;
         ram_addr    <= '0;
         ram_din     <= '0;
         ram_ds      <= '1;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         a_dout      <= '0;
         b_dout      <= '0;
`ifdef SDRAM_ARB_RR_EN
         rr_a        <= 1'b1;
`endif
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;

         if (state == INIT || expire)
            ref_cnt <= REF_LOAD;
         else
            ref_cnt <= ref_cnt - 1'b1;

         // A fresh expiry on the edge that starts a refresh slot re-arms the flag.
         if (expire)
            ref_pending <= 1'b1;
         else if (start && ref_pending)
            ref_pending <= 1'b0;

         case (state)
            INIT: if (ram_ready) state <= IDLE;
            SLOT: begin
               cyc <= cyc + 1'b1;
               if (cyc == CYC_CS_END)
                  ram_cs <= 1'b0;
               if (cyc == CYC_SAMPLE && owner == OWN_A) begin
                  a_ack <= 1'b1;
                  if (!ram_we) a_dout <= ram_dout;
               end
               if (cyc == CYC_SAMPLE && owner == OWN_B) begin
                  b_ack <= 1'b1;
                  if (!ram_we) b_dout <= ram_dout;
               end
               if (slot_end) begin
                  ram_we      <= 1'b0;
                  ram_refresh <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: ;
         endcase

         // A grant overrides the slot-end defaults above.
         if (start) begin
            state  <= SLOT;
            cyc    <= '0;
            ram_cs <= 1'b1;
            if (ref_pending) begin
               owner       <= OWN_REF;
               ram_refresh <= 1'b1;
               ram_we      <= 1'b0;
               ram_ds      <= 2'b11;
            end else if (pick_a) begin
               owner       <= OWN_A;
               ram_refresh <= 1'b0;
               ram_we      <= a_we;
               ram_addr    <= a_addr;
               ram_din     <= a_din;
               ram_ds      <= a_ds;
`ifdef SDRAM_ARB_RR_EN
               rr_a        <= 1'b0;
`endif
            end else begin
               owner       <= OWN_B;
               ram_refresh <= 1'b0;
               ram_we      <= b_we;
               ram_addr    <= b_addr;
               ram_din     <= b_din;
               ram_ds      <= b_ds;
`ifdef SDRAM_ARB_RR_EN
               rr_a        <= 1'b1;
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: timeline reference model checked every cycle, directed literal
// checks for init gating, read/write slots, mid-slot reset, contention and refresh rate.
module tb_sdram_arbiter;
   localparam int SLOT_LEN       = 8;
   localparam int CS_HIGH        = 4;
   localparam int SAMPLE_CYC     = 5;
   localparam int REFRESH_CYCLES = 250;
   localparam int MANUAL = 0, RAND = 1, BUSY = 2;

   logic        clk = 1'b0;
   logic        reset_n, ram_ready;
   logic        ram_cs, ram_we, ram_refresh;
   logic [21:0] ram_addr;
   logic [15:0] ram_din, ram_dout;
   logic [1:0]  ram_ds;
   logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
   logic [21:0] a_addr, b_addr;
   logic [15:0] a_din, b_din, a_dout, b_dout;
   logic [1:0]  a_ds, b_ds;

   sdram_arbiter #(
      .SLOT_LEN(SLOT_LEN), .CS_HIGH(CS_HIGH),
      .SAMPLE_CYC(SAMPLE_CYC), .REFRESH_CYCLES(REFRESH_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ram_ready(ram_ready),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_refresh(ram_refresh),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_ds(ram_ds), .ram_dout(ram_dout),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_ds(a_ds),
      .a_ack(a_ack), .a_dout(a_dout),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_ds(b_ds),
      .b_ack(b_ack), .b_dout(b_dout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, edge_n = 0;

   // Reference model: slot timeline (active flag + offset k), kind 0=refresh 1=A 2=B.
   bit          m_init, m_slot, m_we, m_pending, m_rr_a;
   int          m_k, m_kind, m_since, last_exp, first_exp;
   logic [21:0] m_addr;
   logic [15:0] m_din;
   logic [1:0]  m_ds;
   bit          e_a_ack, e_b_ack;
   logic [15:0] e_a_dout, e_b_dout;

   int          a_mode = MANUAL, b_mode = MANUAL;
   bit          fixed_data;
   logic [15:0] ctrl_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic model_edge();
      bit a_ok, b_ok, can, expire, pick_a, na, nb;
      edge_n++;
      na = 0;
      nb = 0;
      if (!reset_n) begin
         m_init = 1; m_slot = 0; m_k = 0; m_kind = 0; m_we = 0;
         m_pending = 0; m_since = 0; m_rr_a = 1; first_exp = -1; last_exp = -1000;
         e_a_dout = '0; e_b_dout = '0;
      end else if (m_init) begin
         if (ram_ready) m_init = 0;
      end else begin
         a_ok = a_req && !e_a_ack;
         b_ok = b_req && !e_b_ack;
         m_since++;
         expire = (m_since % (REFRESH_CYCLES + 1)) == 0;
         if (m_slot && m_k == SAMPLE_CYC && m_kind == 1) begin
            na = 1;
            if (!m_we) e_a_dout = ram_dout;
         end
         if (m_slot && m_k == SAMPLE_CYC && m_kind == 2) begin
            nb = 1;
            if (!m_we) e_b_dout = ram_dout;
         end
         can = !m_slot || (m_k == SLOT_LEN - 1);
         if (m_slot) begin
            m_k++;
            if (m_k == SLOT_LEN) m_slot = 0;
         end
         if (can && (m_pending || a_ok || b_ok)) begin
            m_slot = 1;
            m_k = 0;
            if (m_pending) begin
               m_kind = 0;
               m_we = 0;
               m_pending = 0;
            end else begin
`ifdef SDRAM_ARB_RR_EN
               pick_a = a_ok && (!b_ok || m_rr_a);
`else
               pick_a = a_ok;
`endif
               m_rr_a = !pick_a;
               m_kind = pick_a ? 1 : 2;
               m_we   = pick_a ? a_we   : b_we;
               m_addr = pick_a ? a_addr : b_addr;
               m_din  = pick_a ? a_din  : b_din;
               m_ds   = pick_a ? a_ds   : b_ds;
            end
         end
         if (expire) begin
            m_pending = 1;
            last_exp = edge_n;
            if (first_exp < 0) first_exp = edge_n;
         end
      end
      e_a_ack = na;
      e_b_ack = nb;
   endtask

   task automatic compare();
      bit req_slot;
      req_slot = m_slot && m_kind != 0;
      chk("ram_cs", ram_cs, m_slot && m_k < CS_HIGH);
      chk("ram_we", ram_we, req_slot && m_we);
      chk("ram_refresh", ram_refresh, m_slot && m_kind == 0);
      if (req_slot) begin
         chk("ram_addr", ram_addr, m_addr);
         chk("ram_din", ram_din, m_din);
         chk("ram_ds", ram_ds, m_ds);
      end
      if (m_slot && m_kind == 0) chk("ram_ds_refresh", ram_ds, 2'b11);
      chk("a_ack", a_ack, e_a_ack);
      chk("b_ack", b_ack, e_b_ack);
      chk("a_dout", a_dout, e_a_dout);
      chk("b_dout", b_dout, e_b_dout);
   endtask

   task automatic port_upd(input int mode, input bit ack, input bit hi, inout logic req,
                           inout logic we, inout logic [21:0] addr, inout logic [15:0] din,
                           inout logic [1:0] ds);
      bit renew;
      renew = 0;
      case (mode)
         MANUAL: if (ack) req = 1'b0;
         RAND: begin
            if (ack) begin
               if ($urandom_range(1) == 1) renew = 1;
               else req = 1'b0;
            end else if (!req && $urandom_range(3) == 0) renew = 1;
         end
         default: if (ack || !req) renew = 1;
      endcase
      if (renew) begin
         req  = 1'b1;
         we   = 1'($urandom_range(1));
         addr = {hi, 21'($urandom)};
         din  = 16'($urandom);
         ds   = 2'($urandom);
      end
   endtask

   // One clock: model takes the edge with the inputs now applied, then outputs are compared
   // at the falling edge and the next interval's stimulus is driven.
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare();
      port_upd(a_mode, e_a_ack, 1'b0, a_req, a_we, a_addr, a_din, a_ds);
      port_upd(b_mode, e_b_ack, 1'b1, b_req, b_we, b_addr, b_din, b_ds);
      if (m_slot && m_k == SAMPLE_CYC && fixed_data) ram_dout = ctrl_data;
      else ram_dout = 16'($urandom);
   endtask

   task automatic wait_cs(input string name);
      int n;
      n = 0;
      while (!ram_cs && n < 50) begin
         step();
         n++;
      end
      chk(name, ram_cs, 1);
   endtask

   initial begin
      int cnt, lat, held, acks, n_ref, n_a, n_b, n_rep, last_owner;
      bit prev_cs;
      reset_n = 0; ram_ready = 0; ram_dout = '0;
      a_req = 0; a_we = 0; a_addr = '0; a_din = '0; a_ds = '1;
      b_req = 0; b_we = 0; b_addr = '0; b_din = '0; b_ds = '1;
      fixed_data = 1; ctrl_data = 16'hBEEF;
      repeat (3) step();

      chk("rst_cs", ram_cs, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_refresh", ram_refresh, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_din", ram_din, 0);
      chk("rst_ds", ram_ds, 2'b11);
      chk("rst_acks", {a_ack, b_ack}, 0);
      chk("rst_douts", {a_dout, b_dout}, 0);

      a_req = 1; a_we = 0; a_addr = 22'h12345; a_din = '0; a_ds = 2'b00;
      reset_n = 1;
      cnt = 0;
      repeat (100) begin
         step();
         if (ram_cs) cnt++;
      end
      chk("init_gate_cs", cnt, 0);
      ram_ready = 1;
      lat = 0;
      while (!ram_cs && lat < 20) begin
         step();
         lat++;
      end
      chk("ready_to_cs", lat, 2);

      held = 0; acks = 0; lat = -1;
      for (int i = 0; i < 20; i++) begin
         if (i < 8 && ram_addr == 22'h12345) held++;
         if (a_ack) begin
            acks++;
            if (lat < 0) lat = i;
         end
         step();
      end
      chk("rd_addr_held", held, 8);
      chk("rd_ack_count", acks, 1);
      chk("rd_ack_latency", lat, 6);
      chk("rd_dout", a_dout, 16'hBEEF);

      b_we = 1; b_addr = 22'h2ABCDE; b_din = 16'hA55A; b_ds = 2'b10; b_req = 1;
      wait_cs("wr_start");
      held = 0; acks = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 8 && ram_we && ram_din == 16'hA55A && ram_ds == 2'b10 && ram_addr == 22'h2ABCDE)
            held++;
         if (i == 8) chk("wr_we_after", ram_we, 0);
         if (b_ack) acks++;
         step();
      end
      chk("wr_held", held, 8);
      chk("wr_ack_count", acks, 1);

      b_req = 1;
      wait_cs("mid_start");
      repeat (3) step();
      reset_n = 0;
      step();
      chk("mid_we", ram_we, 0);
      chk("mid_cs", ram_cs, 0);
      chk("mid_ack", b_ack, 0);
      b_req = 0; acks = 0;
      repeat (5) begin
         step();
         if (b_ack) acks++;
      end
      chk("mid_no_ack", acks, 0);
      reset_n = 1;

      fixed_data = 0; a_mode = RAND; b_mode = RAND;
      repeat (3000) step();

      a_mode = MANUAL; b_mode = MANUAL; a_req = 0; b_req = 0;
      reset_n = 0;
      repeat (2) step();
      reset_n = 1;
      a_mode = BUSY; b_mode = BUSY;
      prev_cs = 0; n_ref = 0; n_a = 0; n_b = 0; n_rep = 0; last_owner = -1;
      for (int i = 0; i < 1400; i++) begin
         step();
         if (ram_cs && !prev_cs) begin
            if (ram_refresh) begin
               if (first_exp >= 0 && edge_n >= first_exp && edge_n < first_exp + 1000) n_ref++;
               chk("ref_wait", (edge_n - last_exp) >= 1 && (edge_n - last_exp) <= SLOT_LEN, 1);
            end else begin
               if (ram_addr[21]) n_b++;
               else n_a++;
               if (last_owner == int'(ram_addr[21])) n_rep++;
               last_owner = int'(ram_addr[21]);
            end
         end
         prev_cs = ram_cs;
      end
      chk("busy_ref_count", n_ref, 4);
`ifdef SDRAM_ARB_RR_EN
      chk("rr_repeats", n_rep, 0);
      chk("rr_b_served", n_b > 100, 1);
`else
      chk("fixed_b_grants", n_b, 0);
      chk("fixed_a_served", n_a > 100, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
      $fatal(1);
   end
endmodule
